// File: rtl/zx_mem_mapper.sv
`default_nettype none
// ============================================================================
// Module   : zx_mem_mapper
// Brief    : Spectrum 128-class memory mapper. Holds the 7FFD/DFFD paging
//            registers, maps CPU addresses onto physical ROM/RAM banks and
//            stretches external RAM cycles with a programmable nWAIT burst.
// Revision : 1.0 - initial release
// ============================================================================
module zx_mem_mapper #(
    parameter int RAM_BANKS   = 8,
    parameter int ROM_PAGES   = 2,
    parameter int EXT_LATENCY = 2
) (
    input  logic                              clk_cpu,
    input  logic                              nreset,
    input  logic [15:0]                       A,
    input  logic [7:0]                        D,
    input  logic                              nMREQ,
    input  logic                              nIORQ,
    input  logic                              nRD,
    input  logic                              nWR,
    output logic [$clog2(ROM_PAGES)+13:0]     rom_addr,
    output logic [$clog2(RAM_BANKS)+13:0]     ram_addr,
    output logic                              rom_cs,
    output logic                              ram_cs,
    output logic                              ram_we,
    output logic                              scr_bank,
    output logic                              nWAIT,
    output logic                              locked,
    output logic [7:0]                        page_reg
);

    localparam int RB = $clog2(RAM_BANKS);
    localparam int RP = $clog2(ROM_PAGES);

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_WAIT = 2'd1;
    localparam logic [1:0]    c_HOLD = 2'd2;

    localparam logic          c_HAS_WAIT = (EXT_LATENCY > 0);
    localparam logic [2:0]    c_LOAD     = (EXT_LATENCY > 0) ? 3'(EXT_LATENCY - 1) : 3'd0;
    localparam logic [RB-1:0] c_BANK5    = RB'(5);
    localparam logic [RB-1:0] c_BANK2    = RB'(2);

    logic [7:0]    r_page_reg;
    logic [3:0]    r_ext_reg;
    logic          r_io_wr_q;
    logic          r_ram_cs_q;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;

    logic          w_io_wr;
    logic          w_io_wr_rise;
    logic          w_dffd_sel;
    logic          w_7ffd_sel;
    logic          w_ram_cs;
    logic [RB-1:0] w_c000_bank;
    logic [RB-1:0] w_bank;
    logic [RP-1:0] w_rom_page;
    logic          w_unused_ext;

    // Bus decode. An OUT is taken only on the first cycle io_wr is seen high,
    // so a write strobe stretched over several clocks captures exactly once.
    assign w_io_wr      = !nIORQ && !nWR && nRD;
    assign w_io_wr_rise = w_io_wr && !r_io_wr_q;
    assign w_dffd_sel   = (A[15:13] == 3'b110) && !A[1];
    assign w_7ffd_sel   = !A[15] && !A[1] && !w_dffd_sel;

    assign w_ram_cs = !nMREQ && (A[15:14] != 2'b00);
    assign ram_cs   = w_ram_cs;
    assign rom_cs   = !nMREQ && (A[15:14] == 2'b00);
    assign ram_we   = w_ram_cs && !nWR && nRD;

    assign page_reg = r_page_reg;
    assign scr_bank = r_page_reg[3];
    assign locked   = r_page_reg[5];

    // Not every ext_reg bit has a consumer in every configuration.
    assign w_unused_ext = &{1'b0, r_ext_reg};

    // C000 bank: ext_reg supplies the bank bits above the three 7FFD bits.
    generate
        if (RB > 3) begin : g_bank_ext
            assign w_c000_bank = {r_ext_reg[RB-4:0], r_page_reg[2:0]};
        end else begin : g_bank_base
            assign w_c000_bank = r_page_reg[2:0];
        end
    endgenerate

    // ROM page: ext_reg[3] becomes the upper page bit on four-page systems.
    generate
        if (RP == 2) begin : g_rom4
            assign w_rom_page = {r_ext_reg[3], r_page_reg[4]};
        end else begin : g_rom2
            assign w_rom_page = r_page_reg[4];
        end
    endgenerate

    // Select the physical RAM bank for the addressed 16K slot.
    always_comb begin
        case (A[15:14])
            2'b01:   w_bank = c_BANK5;
            2'b10:   w_bank = c_BANK2;
            default: w_bank = w_c000_bank;
        endcase
    end

    assign ram_addr = {w_bank, A[13:0]};
    assign rom_addr = {w_rom_page, A[13:0]};

    // Paging registers and edge-detect history; frozen once the lock bit is set.
    always_ff @(posedge clk_cpu or negedge nreset) begin
        if (!nreset) begin
            r_page_reg <= 8'h00;
            r_ext_reg  <= 4'h0;
            r_io_wr_q  <= 1'b0;
            r_ram_cs_q <= 1'b0;
        end else begin
            r_io_wr_q  <= w_io_wr;
            r_ram_cs_q <= w_ram_cs;
            if (w_io_wr_rise && !r_page_reg[5]) begin
                if (w_dffd_sel) begin
                    r_ext_reg <= D[3:0];
                end else if (w_7ffd_sel) begin
                    r_page_reg <= D;
                end
            end
        end
    end

    // Wait generator state and down-counter.
    always_ff @(posedge clk_cpu or negedge nreset) begin
        if (!nreset) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: one burst per RAM cycle, re-armed only after ram_cs drops.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (c_HAS_WAIT && w_ram_cs && !r_ram_cs_q) begin
                    w_state_nxt = c_WAIT;
                    w_cnt_nxt   = c_LOAD;
                end
            end
            c_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = c_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            c_HOLD: begin
                if (!w_ram_cs) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Wait output: low only while counting down.
    always_comb begin
        nWAIT = 1'b1;
        if (r_state == c_WAIT) begin
            nWAIT = 1'b0;
        end
    end

endmodule
`default_nettype wire
